oled_frame_sequencer: RTL and testbench
=======================================

// Module: oled_frame_sequencer
// PURPOSE
//  Upstream command source for OLED_interface. After reset it issues one power-on (turnon) command,
//  then on each frame request walks a NUM_COL x NUM_ROW 1-bit bitmap in row-major order. For each
//  pixel it issues one color command carrying text or background color. All commands use a
//  START/READY handshake that is safe across the interface's divided SCK.
// PARAMETERS
//  NUM_COL       96   columns per frame
//  NUM_ROW       64   rows per frame
//  N_COLOR_BITS  8    color word width (256-color mode)
//  ADDR_W        13   pixel address width, >= clog2(NUM_COL*NUM_ROW)
//  TIMEOUT_TICKS 2000000  i_CLK ticks per handshake wait before error (only with OLED_SEQ_TIMEOUT_EN)
// PORTS
//  i_CLK              in   1             system clock (100 MHz)
//  i_RST              in   1             synchronous, active-high reset
//  i_FRAME_REQ        in   1             1-cycle pulse: send one full frame
//  i_TEXT_COLOR       in   N_COLOR_BITS  color for pixel bit 1; sampled at frame start
//  i_BG_COLOR         in   N_COLOR_BITS  color for pixel bit 0; sampled at frame start
//  o_PIX_ADDR         out  ADDR_W        bitmap read address, row*NUM_COL+col
//  i_PIX_DATA         in   1             bitmap bit, valid 1 cycle after o_PIX_ADDR
//  i_OLED_READY       in   1             o_READY of OLED_interface (SCK domain)
//  o_OLED_START       out  1             START to OLED_interface
//  o_OLED_MODE        out  2             MODE to OLED_interface (00 turnon, 01 color)
//  o_OLED_COLOR       out  N_COLOR_BITS  to i_TEXT_COLOR of OLED_interface
//  o_POWERED          out  1             1 once the turnon command has completed
//  o_BUSY             out  1             1 while a frame is in progress
//  o_FRAME_DONE       out  1             1-cycle pulse after the last pixel completes
//  o_ERROR            out  1             sticky handshake timeout (tied 0 without OLED_SEQ_TIMEOUT_EN)
// BEHAVIOUR
//  Reset values: all outputs are 0; state = PWR_ISSUE; pending = 0; address = 0.
//  i_OLED_READY passes through a 2-FF synchronizer. The rdy_s signal below is that synced value.
//  Handshake per command (HS):
//   - ISSUE: drive MODE/COLOR and assert START.
//   - ACK: hold START, MODE and COLOR until rdy_s = 0.
//   - DONE: deassert START and wait for rdy_s = 1. The command is then complete.
//  MODE and COLOR stay stable from ISSUE through DONE.
//  FSM:
//   - PWR_ISSUE -> PWR_ACK -> PWR_DONE: turnon command (MODE = 00). On completion o_POWERED <= 1 -> IDLE.
//   - IDLE: if pending or i_FRAME_REQ -> latch both colors, clear pending, o_BUSY <= 1,
//     o_PIX_ADDR <= 0 -> FETCH.
//   - FETCH: wait 1 cycle for the read latency -> PX_ISSUE.
//     o_OLED_COLOR <= i_PIX_DATA ? text : bg.
//   - PX_ISSUE -> PX_ACK -> PX_DONE: HS with MODE = 01. On completion -> ADV.
//   - ADV, address == NUM_COL*NUM_ROW-1: address <= 0, o_BUSY <= 0, pulse o_FRAME_DONE -> IDLE.
//   - ADV, otherwise: address+1 -> FETCH.
//  i_FRAME_REQ outside IDLE (including during power-up) sets pending. There is a 1-deep pending flag;
//  further requests merge into it. A request in the o_FRAME_DONE cycle starts the next frame from
//  IDLE with no lost request.
//  Frame requests are never served before o_POWERED = 1.
//  Address arithmetic is unsigned ADDR_W bits. The compare uses the constant NUM_COL*NUM_ROW-1, so
//  there is no implicit wrap.
//  Colors are sampled once per frame; changes mid-frame do not affect the current frame.
//  i_RST at any point aborts immediately: START drops and the FSM restarts at PWR_ISSUE, so a new
//  power-on is issued. i_RST has priority over all inputs.
// CONFIGURATION
//  OLED_SEQ_TIMEOUT_EN defined:
//   - A counter runs in every ACK/DONE state and clears on each state change.
//   - When the count reaches TIMEOUT_TICKS-1: START <= 0, o_ERROR <= 1 (sticky until i_RST),
//     o_BUSY <= 0, pending <= 0, FSM -> IDLE.
//   - A timeout during power-up leaves o_POWERED at 0. Later requests are still only latched, so
//     the block halts until reset.
//  OLED_SEQ_TIMEOUT_EN undefined: no counter; o_ERROR is constant 0; the block waits indefinitely.
// STRUCTURE
//  SSD1331_defines.v carries the shared constants:
//   - mode codes OLED_MODE_TURNON = 2'b00 and OLED_MODE_COLOR = 2'b01
//   - the sequencer state encodings
//  Sub-module oled_start_handshake holds the synchronizer plus the ISSUE/ACK/DONE sub-FSM.
//   - Inputs: req, mode, color.
//   - Outputs: done pulse, timeout pulse.
//   - Top level sequences power-up and pixel iteration only.
// TESTING
//  Bench models OLED_interface READY: drops READY 1 SCK (20 i_CLK) after seeing START, raises it
//  k SCK later.
//  1. Reset release, no requests:
//     - exactly one START with MODE=00;
//     - o_POWERED rises after READY returns;
//     - no further START.
//  2. NUM_COL=4, NUM_ROW=2, bitmap 8'b1010_0110, text=8'hFF, bg=8'h03:
//     - 8 color commands, in address order 0..7;
//     - colors follow each bit (1 -> FF, 0 -> 03);
//     - o_FRAME_DONE pulses once;
//     - o_BUSY falls in the same cycle.
//  3. i_FRAME_REQ during power-up and again mid-frame:
//     - the first frame follows o_POWERED;
//     - exactly one more frame follows;
//     - a 3rd request mid-frame merges (2 frames total).
//  4. Change i_TEXT_COLOR from FF to 1C at pixel 3: all text pixels in the current frame still
//     send FF.
//  5. i_RST asserted while in PX_ACK at address 5:
//     - next cycle START=0, BUSY=0, address=0;
//     - the power-on command is reissued.
//  6. With OLED_SEQ_TIMEOUT_EN and TIMEOUT_TICKS=100, hold READY high after START:
//     - o_ERROR=1 at tick 100;
//     - START=0, FSM in IDLE.
//     Without the macro: START held and o_ERROR stays 0.

Source files
------------

// File: rtl/oled_frame_sequencer_pkg.sv
// Shared constants for the OLED frame sequencer: command mode codes and the
// state encodings of the top-level sequencer and the START/READY handshake.
package oled_frame_sequencer_pkg;

  localparam logic [1:0] OLED_MODE_TURNON = 2'b00;
  localparam logic [1:0] OLED_MODE_COLOR  = 2'b01;

  localparam logic [3:0] SEQ_PWR_ISSUE = 4'd0;
  localparam logic [3:0] SEQ_PWR_ACK   = 4'd1;
  localparam logic [3:0] SEQ_PWR_DONE  = 4'd2;
  localparam logic [3:0] SEQ_IDLE      = 4'd3;
  localparam logic [3:0] SEQ_FETCH     = 4'd4;
  localparam logic [3:0] SEQ_PX_ISSUE  = 4'd5;
  localparam logic [3:0] SEQ_PX_ACK    = 4'd6;
  localparam logic [3:0] SEQ_PX_DONE   = 4'd7;
  localparam logic [3:0] SEQ_ADV       = 4'd8;

  localparam logic [1:0] HS_IDLE = 2'd0;
  localparam logic [1:0] HS_ACK  = 2'd1;
  localparam logic [1:0] HS_DONE = 2'd2;

endpackage

// File: rtl/oled_frame_sequencer_handshake.sv
// START/READY handshake toward OLED_interface: READY synchronizer plus ISSUE/ACK/DONE
// sub-FSM. Optional wait timeout when OLED_SEQ_TIMEOUT_EN is defined.
module oled_start_handshake
  import oled_frame_sequencer_pkg::*;
#(
  parameter int N_COLOR_BITS  = 8,
  parameter int TIMEOUT_TICKS = 2000000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [1:0]              mode_i,
  input  logic [N_COLOR_BITS-1:0] color_i,
  input  logic                    ready_i,
  output logic                    start_o,
  output logic [1:0]              mode_o,
  output logic [N_COLOR_BITS-1:0] color_o,
  output logic                    ack_o,
  output logic                    done_o,
  output logic                    timeout_o
);

  logic [1:0]              hs_q, hs_d;
  logic                    start_q, start_d;
  logic [1:0]              rdy_sync_q;
  logic [1:0]              mode_q;
  logic [N_COLOR_BITS-1:0] color_q;
  logic                    rdy_s;
  logic                    tmo_hit;

  if (TIMEOUT_TICKS < 2) begin : g_bad_timeout
    $error("TIMEOUT_TICKS must be at least 2");
  end

  assign rdy_s = rdy_sync_q[1];

`ifdef OLED_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_TICKS);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (hs_q == HS_IDLE || hs_d != hs_q) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_TICKS - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    hs_d      = hs_q;
    start_d   = start_q;
    ack_o     = 1'b0;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    case (hs_q)
      HS_IDLE: begin
        if (req_i) begin
          hs_d    = HS_ACK;
          start_d = 1'b1;
        end
      end
      HS_ACK: begin
        if (!rdy_s) begin
          hs_d    = HS_DONE;
          start_d = 1'b0;
          ack_o   = 1'b1;
        end else if (tmo_hit) begin
          hs_d      = HS_IDLE;
          start_d   = 1'b0;
          timeout_o = 1'b1;
        end
      end
      HS_DONE: begin
        if (rdy_s) begin
          hs_d   = HS_IDLE;
          done_o = 1'b1;
        end else if (tmo_hit) begin
          hs_d      = HS_IDLE;
          timeout_o = 1'b1;
        end
      end
      default: begin
        hs_d    = HS_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs_q       <= HS_IDLE;
      start_q    <= 1'b0;
      // Synchronizer resets to "ready" so a stale 0 can never fake an acknowledge.
      rdy_sync_q <= 2'b11;
      mode_q     <= '0;
      color_q    <= '0;
    end else begin
      hs_q       <= hs_d;
      start_q    <= start_d;
      rdy_sync_q <= {rdy_sync_q[0], ready_i};
      if (hs_q == HS_IDLE && req_i) begin
        mode_q  <= mode_i;
        color_q <= color_i;
      end
    end
  end

  assign start_o = start_q;
  assign mode_o  = mode_q;
  assign color_o = color_q;

endmodule

// File: rtl/oled_frame_sequencer.sv
// Command source for OLED_interface: one turnon command after reset, then one color command per
// bitmap pixel per frame request. Build option OLED_SEQ_TIMEOUT_EN enables handshake timeouts.
module oled_frame_sequencer
  import oled_frame_sequencer_pkg::*;
#(
  parameter int NUM_COL       = 96,
  parameter int NUM_ROW       = 64,
  parameter int N_COLOR_BITS  = 8,
  parameter int ADDR_W        = 13,
  parameter int TIMEOUT_TICKS = 2000000
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_FRAME_REQ,
  input  logic [N_COLOR_BITS-1:0] i_TEXT_COLOR,
  input  logic [N_COLOR_BITS-1:0] i_BG_COLOR,
  output logic [ADDR_W-1:0]       o_PIX_ADDR,
  input  logic                    i_PIX_DATA,
  input  logic                    i_OLED_READY,
  output logic                    o_OLED_START,
  output logic [1:0]              o_OLED_MODE,
  output logic [N_COLOR_BITS-1:0] o_OLED_COLOR,
  output logic                    o_POWERED,
  output logic                    o_BUSY,
  output logic                    o_FRAME_DONE,
  output logic                    o_ERROR
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_COL * NUM_ROW - 1);

  if (ADDR_W < $clog2(NUM_COL * NUM_ROW)) begin : g_bad_addr_w
    $error("ADDR_W too narrow for NUM_COL*NUM_ROW");
  end

  logic [3:0]              state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [N_COLOR_BITS-1:0] text_q, text_d, bg_q, bg_d;
  logic                    pending_q, pending_d;
  logic                    powered_q, powered_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    hs_req, hs_ack, hs_done, hs_timeout;
  logic [1:0]              hs_mode;
  logic [N_COLOR_BITS-1:0] hs_color;

  // Pixel data lags the address by one cycle, so it is consumed in PX_ISSUE, not FETCH.
  assign hs_req   = (state_q == SEQ_PWR_ISSUE) || (state_q == SEQ_PX_ISSUE);
  assign hs_mode  = (state_q == SEQ_PX_ISSUE) ? OLED_MODE_COLOR : OLED_MODE_TURNON;
  assign hs_color = (state_q != SEQ_PX_ISSUE) ? '0 : (i_PIX_DATA ? text_q : bg_q);

  oled_start_handshake #(
    .N_COLOR_BITS (N_COLOR_BITS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_handshake (
    .clk_i    (i_CLK),
    .rst_i    (i_RST),
    .req_i    (hs_req),
    .mode_i   (hs_mode),
    .color_i  (hs_color),
    .ready_i  (i_OLED_READY),
    .start_o  (o_OLED_START),
    .mode_o   (o_OLED_MODE),
    .color_o  (o_OLED_COLOR),
    .ack_o    (hs_ack),
    .done_o   (hs_done),
    .timeout_o(hs_timeout)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    text_d    = text_q;
    bg_d      = bg_q;
    pending_d = pending_q | i_FRAME_REQ;
    powered_d = powered_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    case (state_q)
      SEQ_PWR_ISSUE: state_d = SEQ_PWR_ACK;
      SEQ_PWR_ACK:   if (hs_ack) state_d = SEQ_PWR_DONE;
      SEQ_PWR_DONE: begin
        if (hs_done) begin
          powered_d = 1'b1;
          state_d   = SEQ_IDLE;
        end
      end
      SEQ_IDLE: begin
        if (powered_q && (pending_q || i_FRAME_REQ)) begin
          text_d    = i_TEXT_COLOR;
          bg_d      = i_BG_COLOR;
          pending_d = 1'b0;
          busy_d    = 1'b1;
          addr_d    = '0;
          state_d   = SEQ_FETCH;
        end
      end
      SEQ_FETCH:    state_d = SEQ_PX_ISSUE;
      SEQ_PX_ISSUE: state_d = SEQ_PX_ACK;
      SEQ_PX_ACK:   if (hs_ack) state_d = SEQ_PX_DONE;
      SEQ_PX_DONE:  if (hs_done) state_d = SEQ_ADV;
      SEQ_ADV: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = SEQ_IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = SEQ_FETCH;
        end
      end
      default: state_d = SEQ_PWR_ISSUE;
    endcase
    // A timeout abandons power-up or the frame; o_POWERED stays as it was.
    if (hs_timeout) begin
      state_d   = SEQ_IDLE;
      busy_d    = 1'b0;
      pending_d = 1'b0;
      error_d   = 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= SEQ_PWR_ISSUE;
      addr_q    <= '0;
      text_q    <= '0;
      bg_q      <= '0;
      pending_q <= 1'b0;
      powered_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      text_q    <= text_d;
      bg_q      <= bg_d;
      pending_q <= pending_d;
      powered_q <= powered_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign o_PIX_ADDR   = addr_q;
  assign o_POWERED    = powered_q;
  assign o_BUSY       = busy_q;
  assign o_FRAME_DONE = done_q;
`ifdef OLED_SEQ_TIMEOUT_EN
  assign o_ERROR      = error_q;
`else
  assign o_ERROR      = 1'b0;
`endif

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Randomized bench for oled_frame_sequencer on a 4x2 bitmap with a behavioural OLED_interface
// READY model; expected command streams are derived from bitmap and colors.
module tb_oled_frame_sequencer;

  localparam int NUM_COL = 4;
  localparam int NUM_ROW = 2;
  localparam int NPIX    = NUM_COL * NUM_ROW;
  localparam int AW      = 3;
  localparam int TMO     = 100;
  localparam int SCK     = 20;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] color;
    logic [2:0] addr;
    logic       powered;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_req = 1'b0;
  logic [7:0]    text = 8'h00;
  logic [7:0]    bg = 8'h00;
  logic          pix_data = 1'b0;
  logic          oled_ready = 1'b1;
  logic [AW-1:0] pix_addr;
  logic          oled_start, powered, busy, frame_done, error;
  logic [1:0]    oled_mode;
  logic [7:0]    oled_color;

  always #5 clk = ~clk;

  oled_frame_sequencer #(
    .NUM_COL(NUM_COL), .NUM_ROW(NUM_ROW), .N_COLOR_BITS(8), .ADDR_W(AW), .TIMEOUT_TICKS(TMO)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_FRAME_REQ(frame_req),
    .i_TEXT_COLOR(text), .i_BG_COLOR(bg),
    .o_PIX_ADDR(pix_addr), .i_PIX_DATA(pix_data), .i_OLED_READY(oled_ready),
    .o_OLED_START(oled_start), .o_OLED_MODE(oled_mode), .o_OLED_COLOR(oled_color),
    .o_POWERED(powered), .o_BUSY(busy), .o_FRAME_DONE(frame_done), .o_ERROR(error)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bitmap memory with one cycle of read latency.
  logic [NPIX-1:0] bm = '0;
  logic [AW-1:0]   addr_seen = '0;
  always @(negedge clk) begin
    pix_data  = bm[addr_seen];
    addr_seen = pix_addr;
  end

  // OLED_interface READY: drop 1 SCK after START, rise k SCK later.
  int m_phase = 0;
  int m_cnt = 0;
  bit hold_ready = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      m_phase    = 0;
      oled_ready = 1'b1;
    end else begin
      case (m_phase)
        0: if (oled_start) begin m_phase = 1; m_cnt = SCK; end
        1: begin
          m_cnt--;
          if (m_cnt <= 0 && !hold_ready) begin
            oled_ready = 1'b0;
            m_cnt      = SCK * int'($urandom_range(1, 3));
            m_phase    = 2;
          end
        end
        2: begin
          m_cnt--;
          if (m_cnt <= 0) begin oled_ready = 1'b1; m_phase = 3; end
        end
        default: if (!oled_start) m_phase = 0;
      endcase
    end
  end

  // Monitor: record every issued command and frame completion.
  cmd_t       obs[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         start_cyc = 0;
  int         err_cyc = 0;
  logic       start_prev = 1'b0, busy_prev = 1'b0, powered_prev = 1'b0, error_prev = 1'b0;
  logic [1:0] rise_mode = '0;
  logic [7:0] rise_color = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    cmd_t c;
    if (oled_start && !start_prev) begin
      c.mode = oled_mode; c.color = oled_color; c.addr = pix_addr; c.powered = powered;
      obs.push_back(c);
      rise_mode  = oled_mode;
      rise_color = oled_color;
      start_cyc  = cyc;
    end
    if (!oled_start && start_prev && !rst)
      check("cmd_stable", {oled_mode, oled_color}, {rise_mode, rise_color});
    if (frame_done) begin
      done_cnt++;
      check("busy_fall_with_done", {busy_prev, busy}, 2'b10);
    end
    if (powered && !powered_prev) check("powered_after_ready", oled_ready, 1'b1);
    if (error && !error_prev) err_cyc = cyc;
    start_prev   = oled_start;
    busy_prev    = busy;
    powered_prev = powered;
    error_prev   = error;
  end

  task automatic pulse_req();
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  task automatic wait_powered(input string tag);
    int n = 0;
    while (!powered && n < 5000) begin @(negedge clk); n++; end
    check(tag, powered, 1'b1);
  endtask

  task automatic wait_obs(input int target, input string tag);
    int n = 0;
    while (obs.size() < target && n < 5000) begin @(negedge clk); n++; end
    check(tag, obs.size() >= target, 1'b1);
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 20000) begin @(negedge clk); n++; end
    check(tag, done_cnt >= target, 1'b1);
  endtask

  // Reference: one color command per pixel, row-major, color chosen by the pixel bit.
  task automatic expect_frame(input logic [NPIX-1:0] map, input logic [7:0] t,
                              input logic [7:0] b, input int base);
    for (int p = 0; p < NPIX; p++) begin
      if (base + p < obs.size()) begin
        check("px_mode", obs[base+p].mode, 2'b01);
        check("px_addr", obs[base+p].addr, p);
        check("px_color", obs[base+p].color, map[p] ? t : b);
        check("px_after_power", obs[base+p].powered, 1'b1);
      end else begin
        check("px_missing", obs.size(), base + p + 1);
      end
    end
  endtask

  initial begin
    int base, d0;
    logic [7:0] t_a, b_a;

    // 1: reset state, single power-on command, then silence.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {oled_start, oled_mode, oled_color, pix_addr, powered, busy, frame_done, error}, '0);
    rst = 1'b0;
    wait_powered("powerup_done");
    check("powerup_cmds", obs.size(), 1);
    if (obs.size() > 0) check("powerup_mode", obs[0].mode, 2'b00);
    repeat (300) @(negedge clk);
    check("no_extra_start", obs.size(), 1);
    check("idle_not_busy", busy, 1'b0);

    // 2: fixed bitmap frame.
    bm = 8'b1010_0110; text = 8'hFF; bg = 8'h03;
    base = obs.size(); d0 = done_cnt;
    pulse_req();
    wait_frames(d0 + 1, "frame2_done");
    repeat (50) @(negedge clk);
    check("frame2_cmds", obs.size() - base, NPIX);
    check("frame2_done_once", done_cnt, d0 + 1);
    expect_frame(bm, 8'hFF, 8'h03, base);

    // 3: request during power-up, two more mid-frame merge into one.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs.delete();
    bm = NPIX'($urandom); t_a = 8'($urandom); b_a = 8'($urandom);
    text = t_a; bg = b_a;
    rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    pulse_req();
    wait_obs(4, "merge_first_px");
    pulse_req();
    wait_obs(7, "merge_mid_px");
    pulse_req();
    wait_frames(d0 + 2, "merge_two_frames");
    repeat (1500) @(negedge clk);
    check("merge_frame_count", done_cnt, d0 + 2);
    check("merge_cmd_count", obs.size(), 1 + 2 * NPIX);
    expect_frame(bm, t_a, b_a, 1);
    expect_frame(bm, t_a, b_a, 1 + NPIX);

    // 4: text color change mid-frame applies only to the next frame.
    bm = NPIX'($urandom) | 8'b0010_0000; b_a = 8'($urandom);
    text = 8'hFF; bg = b_a;
    base = obs.size(); d0 = done_cnt;
    pulse_req();
    wait_obs(base + 4, "color_px3");
    text = 8'h1C;
    wait_frames(d0 + 1, "color_frame_done");
    expect_frame(bm, 8'hFF, b_a, base);
    base = obs.size();
    pulse_req();
    wait_frames(d0 + 2, "color_next_done");
    repeat (20) @(negedge clk);
    expect_frame(bm, 8'h1C, b_a, base);

    // 5: reset while waiting for acknowledge of pixel 5.
    bm = NPIX'($urandom);
    base = obs.size();
    pulse_req();
    wait_obs(base + 6, "abort_px5");
    if (obs.size() > base + 5) check("abort_at_addr5", obs[base+5].addr, 5);
    rst = 1'b1;
    @(negedge clk);
    check("abort_start", oled_start, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_addr", pix_addr, 0);
    @(negedge clk);
    obs.delete();
    rst = 1'b0;
    wait_powered("abort_repower");
    check("abort_repower_cmds", obs.size(), 1);
    if (obs.size() > 0) check("abort_repower_mode", obs[0].mode, 2'b00);

    // 6: READY never drops after START.
    hold_ready = 1'b1;
    base = obs.size();
    pulse_req();
    wait_obs(base + 1, "stuck_start");
`ifdef OLED_SEQ_TIMEOUT_EN
    begin
      int n = 0;
      while (!error && n < 1000) begin @(negedge clk); n++; end
      @(negedge clk);
      check("tmo_error", error, 1'b1);
      check("tmo_tick", err_cyc - start_cyc, TMO);
      check("tmo_start_low", oled_start, 1'b0);
      check("tmo_not_busy", busy, 1'b0);
    end
`else
    repeat (300) @(negedge clk);
    check("stuck_start_held", oled_start, 1'b1);
    check("stuck_no_error", error, 1'b0);
    check("stuck_busy", busy, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
